// File: rtl/fifo_player_pkg.sv
// Shared types and default widths for the FIFO sample player.
package fifo_player_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned DIV_WIDTH_DEF  = 16;
    localparam int unsigned CNT_WIDTH_DEF  = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        PLAY     = 2'd2,
        UNDERRUN = 2'd3
    } player_state_t;

endpackage

// File: rtl/fifo_sample_player_if.sv
// FIFO read port and DAC output bundle of the sample player.
interface fifo_sample_player_if
    import fifo_player_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) ();

    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] dac_data;
    logic                  dac_strobe;

    // Player side: consumes the FIFO head and drives the DAC.
    modport master (
        input  fifo_rd_data,
        input  fifo_empty,
        output fifo_rd_en,
        output dac_data,
        output dac_strobe
    );

    // Environment side: FIFO read port and DAC sink.
    modport slave (
        output fifo_rd_data,
        output fifo_empty,
        input  fifo_rd_en,
        input  dac_data,
        input  dac_strobe
    );

endinterface

// File: rtl/sample_tick_gen.sv
// Loadable down-counter; tick_c is high while the count sits at zero.
module sample_tick_gen
    import fifo_player_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             tick_c
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Load has priority; decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_c = (cnt_q == '0);

endmodule

// File: rtl/fifo_sample_player.sv
// Playout-domain FIFO consumer: paces pops by the divider, feeds the DAC,
// flags underrun and drives idle_value while stopped.
module fifo_sample_player
    import fifo_player_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DIV_WIDTH  = DIV_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DIV_WIDTH-1:0]  divider,
    input  logic [DATA_WIDTH-1:0] idle_value,
    input  logic                  underrun_clr,
    output logic                  running,
    output logic                  underrun,
    output logic [CNT_WIDTH-1:0]  sample_count,
    fifo_sample_player_if.master  pif
);

    player_state_t         state_q,        state_d;
    logic [DATA_WIDTH-1:0] dac_data_q,     dac_data_d;
    logic                  dac_strobe_q,   dac_strobe_d;
    logic                  running_q,      running_d;
    logic                  underrun_q,     underrun_d;
    logic [CNT_WIDTH-1:0]  sample_count_q, sample_count_d;
    logic [DIV_WIDTH-1:0]  div_q,          div_d;

    logic                  fifo_rd_en_c;
    logic                  tick_c;
    logic                  tick_load_c;
    logic [DIV_WIDTH-1:0]  tick_load_val_c;
    logic                  tick_dec_c;

    sample_tick_gen #(
        .WIDTH (DIV_WIDTH)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .load     (tick_load_c),
        .load_val (tick_load_val_c),
        .dec      (tick_dec_c),
        .tick_c   (tick_c)
    );

    // Next state, pop decision and next output values; enable=0 overrides all.
    always_comb begin
        state_d         = state_q;
        dac_data_d      = dac_data_q;
        dac_strobe_d    = 1'b0;
        underrun_d      = underrun_q;
        sample_count_d  = sample_count_q;
        div_d           = div_q;
        fifo_rd_en_c    = 1'b0;
        tick_load_c     = 1'b0;
        tick_load_val_c = '0;
        tick_dec_c      = 1'b0;

        if (underrun_clr) begin
            underrun_d = 1'b0;
        end

        if (state_q == IDLE) begin
            dac_data_d = idle_value;
        end

        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d        = ARMED;
                    div_d          = divider;
                    sample_count_d = '0;
                end
                ARMED: begin
                    // Counter starts at zero so PLAY pops on its first cycle.
                    if (!pif.fifo_empty) begin
                        state_d     = PLAY;
                        tick_load_c = 1'b1;
                    end
                end
                PLAY: begin
                    if (tick_c) begin
                        if (!pif.fifo_empty) begin
                            fifo_rd_en_c    = 1'b1;
                            dac_data_d      = pif.fifo_rd_data;
                            dac_strobe_d    = 1'b1;
                            tick_load_c     = 1'b1;
                            tick_load_val_c = div_q;
                            if (sample_count_q != '1) begin
                                sample_count_d = sample_count_q + CNT_WIDTH'(1);
                            end
                        end else begin
                            // Set after the clear so a same-cycle event wins.
                            underrun_d = 1'b1;
                            state_d    = UNDERRUN;
                        end
                    end else begin
                        tick_dec_c = 1'b1;
                    end
                end
                UNDERRUN: begin
                    state_d = UNDERRUN;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        running_d = (state_d == PLAY);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            dac_data_q     <= '0;
            dac_strobe_q   <= 1'b0;
            running_q      <= 1'b0;
            underrun_q     <= 1'b0;
            sample_count_q <= '0;
            div_q          <= '0;
        end else begin
            state_q        <= state_d;
            dac_data_q     <= dac_data_d;
            dac_strobe_q   <= dac_strobe_d;
            running_q      <= running_d;
            underrun_q     <= underrun_d;
            sample_count_q <= sample_count_d;
            div_q          <= div_d;
        end
    end

    assign pif.fifo_rd_en = fifo_rd_en_c;
    assign pif.dac_data   = dac_data_q;
    assign pif.dac_strobe = dac_strobe_q;
    assign running        = running_q;
    assign underrun       = underrun_q;
    assign sample_count   = sample_count_q;

endmodule

// File: tb/tb_fifo_sample_player.sv
// Bench for fifo_sample_player with a gray-pointer dual-clock FIFO feeding it.
module tb_fifo_sample_player;
    import fifo_player_pkg::*;

    localparam int unsigned DW   = 16;
    localparam int unsigned DIVW = 16;
    localparam int unsigned CW   = 32;
    localparam int unsigned AW   = 4;
    localparam logic [DW-1:0] IDLE_VAL = 16'h8000;

    logic            clk        = 1'b0;
    logic            wr_clk     = 1'b0;
    logic            rst        = 1'b1;
    logic            enable     = 1'b0;
    logic [DIVW-1:0] divider    = '0;
    logic [DW-1:0]   idle_value = IDLE_VAL;
    logic            underrun_clr = 1'b0;
    logic            running;
    logic            underrun;
    logic [CW-1:0]   sample_count;

    fifo_sample_player_if #(.DATA_WIDTH(DW)) pif ();

    fifo_sample_player #(
        .DATA_WIDTH (DW),
        .DIV_WIDTH  (DIVW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .divider      (divider),
        .idle_value   (idle_value),
        .underrun_clr (underrun_clr),
        .running      (running),
        .underrun     (underrun),
        .sample_count (sample_count),
        .pif          (pif)
    );

    always #5 clk    = ~clk;
    always #7 wr_clk = ~wr_clk;

    // Dual-clock FIFO, depth 16, first-word-fall-through
    logic [DW-1:0] mem [2**AW];
    logic [AW:0]   wbin, rbin, wgray, rgray;
    logic [AW:0]   wg_s1, wg_s2, rg_s1, rg_s2;
    logic          wr_en   = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          full;

    assign wgray = wbin ^ (wbin >> 1);
    assign rgray = rbin ^ (rbin >> 1);
    assign full  = (wgray == {~rg_s2[AW:AW-1], rg_s2[AW-2:0]});
    assign pif.fifo_empty   = (rgray == wg_s2);
    assign pif.fifo_rd_data = mem[rbin[AW-1:0]];

    always @(posedge wr_clk) if (wr_en && !full) mem[wbin[AW-1:0]] <= wr_data;

    always @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            wbin  <= '0;
            rg_s1 <= '0;
            rg_s2 <= '0;
        end else begin
            if (wr_en && !full) wbin <= wbin + 1'b1;
            rg_s1 <= rgray;
            rg_s2 <= rg_s1;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rbin  <= '0;
            wg_s1 <= '0;
            wg_s2 <= '0;
        end else begin
            if (pif.fifo_rd_en) rbin <= rbin + 1'b1;
            wg_s1 <= wgray;
            wg_s2 <= wg_s1;
        end
    end

    // Checking
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Scoreboard and monitor
    logic [DW-1:0] exp_q [$];
    int cyc = 0;
    int pop_cnt = 0;
    int strobe_cnt = 0;
    int run_len = 0;
    int last_run = 0;
    int test_id = 0;
    int gap_exp = 0;
    int mon_test = -1;
    int last_cyc = 0;
    bit have_last = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (pif.fifo_rd_en) begin
            check("pop_while_empty", 32'(pif.fifo_empty), 32'd0);
            pop_cnt++;
            run_len++;
        end else begin
            if (run_len != 0) last_run = run_len;
            run_len = 0;
        end
        if (pif.dac_strobe) begin
            strobe_cnt++;
            if (exp_q.size() == 0) begin
                check("strobe_without_sample", 32'(exp_q.size()), 32'd1);
            end else begin
                check("dac_data", 32'(pif.dac_data), 32'(exp_q.pop_front()));
            end
            if (mon_test != test_id) begin
                mon_test  = test_id;
                have_last = 1'b0;
            end
            if (have_last && gap_exp != 0) check("strobe_gap", 32'(cyc - last_cyc), 32'(gap_exp));
            last_cyc  = cyc;
            have_last = 1'b1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_word(input logic [DW-1:0] v);
        @(posedge wr_clk);
        #1;
        check("fifo_full_on_write", 32'(full), 32'd0);
        wr_data = v;
        wr_en   = 1'b1;
        exp_q.push_back(v);
        @(posedge wr_clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_underrun(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (underrun) break;
        end
        check(tag, 32'(underrun), 32'd1);
    endtask

    task automatic wait_pops(input string tag, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (pop_cnt == target) break;
        end
        check(tag, 32'(pop_cnt), 32'(target));
    endtask

    int base_pops;
    int base_strobes;

    initial begin
        // 1: reset and idle
        step(3);
        check("rst_dac_data", 32'(pif.dac_data), 32'd0);
        check("rst_strobe", 32'(pif.dac_strobe), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_count", sample_count, 32'd0);
        rst = 1'b0;
        step(1);
        check("idle_value_after_release", 32'(pif.dac_data), 32'(IDLE_VAL));
        step(5);
        check("idle_no_pop", 32'(pop_cnt), 32'd0);

        // 2: divider=3, eight words, then underrun
        test_id = 2;
        gap_exp = 4;
        divider = 16'd3;
        for (int i = 1; i <= 8; i++) wr_word(16'(i));
        step(6);
        enable = 1'b1;
        wait_underrun("t2_underrun", 200);
        check("t2_count", sample_count, 32'd8);
        check("t2_strobes", 32'(strobe_cnt), 32'd8);
        check("t2_hold", 32'(pif.dac_data), 32'd8);
        check("t2_running", 32'(running), 32'd0);
        check("t2_sb_drained", 32'(exp_q.size()), 32'd0);
        step(10);
        check("t2_hold_later", 32'(pif.dac_data), 32'd8);
        check("t2_no_more_pops", 32'(pop_cnt), 32'd8);

        // 4: clear with enable drop, re-arm on empty FIFO, resume on first write
        test_id = 4;
        gap_exp = 0;
        underrun_clr = 1'b1;
        enable = 1'b0;
        step(1);
        underrun_clr = 1'b0;
        check("t4_underrun_clr", 32'(underrun), 32'd0);
        check("t4_running", 32'(running), 32'd0);
        step(1);
        check("t4_idle_value", 32'(pif.dac_data), 32'(IDLE_VAL));
        enable = 1'b1;
        step(10);
        check("t4_armed_not_running", 32'(running), 32'd0);
        check("t4_armed_no_underrun", 32'(underrun), 32'd0);
        check("t4_count_cleared", sample_count, 32'd0);
        check("t4_armed_no_pop", 32'(pop_cnt), 32'd8);
        wr_word(16'h1234);
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (sample_count != 0) break;
        end
        check("t4_count_restart", sample_count, 32'd1);
        check("t4_running", 32'(running), 32'd1);
        wait_underrun("t4_underrun", 50);
        enable = 1'b0;
        underrun_clr = 1'b1;
        step(1);
        underrun_clr = 1'b0;
        step(2);

        // 3: divider=0, sixteen back-to-back pops
        test_id = 3;
        gap_exp = 1;
        divider = 16'd0;
        base_strobes = strobe_cnt;
        for (int i = 0; i < 16; i++) wr_word(16'h0100 + 16'(i));
        step(6);
        enable = 1'b1;
        wait_underrun("t3_underrun", 100);
        check("t3_pop_run", 32'(last_run), 32'd16);
        check("t3_count", sample_count, 32'd16);
        check("t3_strobes", 32'(strobe_cnt - base_strobes), 32'd16);
        check("t3_sb_drained", 32'(exp_q.size()), 32'd0);

        // 5: drop enable in the cycle that would pop word 3
        enable = 1'b0;
        underrun_clr = 1'b1;
        step(1);
        underrun_clr = 1'b0;
        step(1);
        test_id = 5;
        gap_exp = 4;
        divider = 16'd3;
        for (int i = 1; i <= 8; i++) wr_word(16'h0050 + 16'(i));
        step(6);
        base_pops = pop_cnt;
        enable = 1'b1;
        wait_pops("t5_two_pops", base_pops + 2, 100);
        step(3);
        enable = 1'b0;
        step(1);
        check("t5_no_pop_on_drop", 32'(pop_cnt), 32'(base_pops + 2));
        check("t5_no_strobe", 32'(pif.dac_strobe), 32'd0);
        step(1);
        check("t5_idle_value", 32'(pif.dac_data), 32'(IDLE_VAL));
        check("t5_fifo_level", 32'(5'(wbin - rbin)), 32'd6);
        check("t5_sb_left", 32'(exp_q.size()), 32'd6);
        check("t5_running", 32'(running), 32'd0);

        // 6: asynchronous reset mid-PLAY
        test_id = 6;
        base_pops = pop_cnt;
        enable = 1'b1;
        wait_pops("t6_two_pops", base_pops + 2, 100);
        @(posedge clk);
        #3;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("t6_async_dac_data", 32'(pif.dac_data), 32'd0);
        check("t6_async_strobe", 32'(pif.dac_strobe), 32'd0);
        check("t6_async_running", 32'(running), 32'd0);
        check("t6_async_underrun", 32'(underrun), 32'd0);
        check("t6_async_count", sample_count, 32'd0);
        enable = 1'b0;
        step(3);
        rst = 1'b0;
        base_pops    = pop_cnt;
        base_strobes = strobe_cnt;
        step(10);
        check("t6_no_strobe", 32'(strobe_cnt), 32'(base_strobes));
        check("t6_no_pop", 32'(pop_cnt), 32'(base_pops));
        check("t6_idle_running", 32'(running), 32'd0);
        check("t6_idle_value", 32'(pif.dac_data), 32'(IDLE_VAL));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
